// File: rtl/fft_capture_ctrl_if.sv
// Register bus and FFT sink stream bundle for fft_capture_ctrl.
// The slave modport is the capture block; the master modport is the CPU/FFT side.
interface fft_capture_ctrl_if #(
    parameter int DATA_SIZE = 28
);
    logic                 chipselect;
    logic [1:0]           address;
    logic                 read;
    logic                 write;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic                 sink_valid;
    logic [DATA_SIZE-1:0] sink_data;
    logic                 sink_sop;
    logic                 sink_eop;
    logic                 sink_ready;

    modport master (
        output chipselect, address, read, write, write_data,
        output sink_valid, sink_data, sink_sop, sink_eop,
        input  read_data, sink_ready
    );

    modport slave (
        input  chipselect, address, read, write, write_data,
        input  sink_valid, sink_data, sink_sop, sink_eop,
        output read_data, sink_ready
    );
endinterface

// File: rtl/fft_capture_ctrl.sv
// Captures FFT output frames into a FIFO and exposes them through a 4-register bus.
// Optional macro FFT_CAPTURE_ERR_CNT_EN adds a saturating error counter at COUNT[31:16].
module fft_capture_ctrl #(
    parameter int DATA_SIZE  = 28,
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    fft_capture_ctrl_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int BW = $clog2(FRAME_LEN);
    localparam logic [BW-1:0] LAST_BIN = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [BW-1:0]        bin_cnt;
    logic [15:0]          frame_cnt;
    logic [15:0]          err_cnt;
    logic                 err, done, continuous, rdy_en;
    logic [31:0]          read_data_q;

    logic fifo_full, fifo_empty, sink_ready_int, xfer;
    logic ctrl_wr, do_arm, do_clear, do_abort, bus_rd, pop, push;
    logic resync, early_eop, frame_end, err_event;
    logic [4:0]  level5;
    logic [31:0] status_word, head_word;
    logic        unused_wdata;

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);

    // rdy_en holds sink_ready low through reset and until the first clock edge after it
    assign sink_ready_int = rdy_en & ((state != CAPTURE) | ~fifo_full);
    assign bus.sink_ready = sink_ready_int;
    assign bus.read_data  = read_data_q;
    assign xfer           = bus.sink_valid & sink_ready_int;

    assign ctrl_wr  = bus.chipselect & bus.write & (bus.address == 2'd2);
    assign do_arm   = ctrl_wr & bus.write_data[0];
    assign do_clear = ctrl_wr & bus.write_data[2];
    assign do_abort = ctrl_wr & bus.write_data[3];
    assign unused_wdata = ^bus.write_data[31:4];

    assign bus_rd = bus.chipselect & bus.read;
    assign pop    = bus_rd & (bus.address == 2'd0) & ~fifo_empty;
    assign push   = xfer & ((state == CAPTURE) | ((state == WAIT_SOP) & bus.sink_sop))
                  & ~fifo_full & ~do_clear & ~do_abort;

    assign resync    = bus.sink_sop & (bin_cnt != '0);
    assign early_eop = bus.sink_eop & (bin_cnt != LAST_BIN);
    assign frame_end = (state == CAPTURE) & xfer
                     & (bus.sink_eop | (~resync & (bin_cnt == LAST_BIN)));
    assign err_event = (state == CAPTURE) & xfer & (resync | early_eop);

    assign level5      = 5'(level);
    assign status_word = {18'b0, fifo_empty, fifo_full, state, err, done, 3'b0, level5};
    assign head_word   = 32'(mem[rd_ptr]);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.sink_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            bin_cnt     <= '0;
            frame_cnt   <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            continuous  <= 1'b0;
            rdy_en      <= 1'b0;
            read_data_q <= '0;
        end else begin
            rdy_en <= 1'b1;

            if (do_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
            end

            if (bus_rd) begin
                case (bus.address)
                    2'd0: read_data_q <= fifo_empty ? '0 : head_word;
                    2'd1: read_data_q <= status_word;
                    2'd2: read_data_q <= {30'b0, continuous, 1'b0};
                    2'd3: read_data_q <= {err_cnt, frame_cnt};
                endcase
            end

            case (state)
                WAIT_SOP: begin
                    if (xfer && bus.sink_sop) begin
                        state   <= CAPTURE;
                        bin_cnt <= BW'(1);
                    end
                end
                CAPTURE: begin
                    if (frame_end) begin
                        bin_cnt <= '0;
                        state   <= continuous ? WAIT_SOP : DONE;
                    end else if (xfer) begin
                        bin_cnt <= resync ? BW'(1) : bin_cnt + BW'(1);
                    end
                end
                default: ;
            endcase

            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                done      <= 1'b1;
            end
            if (err_event) err <= 1'b1;

            // Control write is applied last so clear/abort override frame bookkeeping
            if (ctrl_wr) begin
                continuous <= bus.write_data[1];
                if (do_arm && (state == IDLE || state == DONE)) state <= WAIT_SOP;
            end
            if (do_clear) begin
                err       <= 1'b0;
                done      <= 1'b0;
                frame_cnt <= '0;
            end
            if (do_abort) begin
                state   <= IDLE;
                bin_cnt <= '0;
            end
        end
    end

`ifdef FFT_CAPTURE_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       err_cnt <= '0;
        else if (do_clear)                  err_cnt <= '0;
        else if (err_event && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_capture_ctrl.sv
// Bench for fft_capture_ctrl: directed scenarios plus random traffic against a queue-based model.
// Instance A uses FRAME_LEN=8, instance B uses FRAME_LEN=32; both FIFO_DEPTH=16.
module tb_fft_capture_ctrl;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    fft_capture_ctrl_if #(.DATA_SIZE(28)) ifa ();
    fft_capture_ctrl_if #(.DATA_SIZE(28)) ifb ();

    fft_capture_ctrl #(.DATA_SIZE(28), .FRAME_LEN(8), .FIFO_DEPTH(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    fft_capture_ctrl #(.DATA_SIZE(28), .FRAME_LEN(32), .FIFO_DEPTH(16)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    logic        sel;
    logic        t_cs, t_rd, t_wr, t_v, t_sop, t_eop;
    logic [1:0]  t_addr;
    logic [31:0] t_wd;
    logic [27:0] t_d;
    logic        obs_ready;
    logic [31:0] obs_rd;

    assign ifa.chipselect = t_cs & ~sel;
    assign ifa.read       = t_rd;
    assign ifa.write      = t_wr;
    assign ifa.address    = t_addr;
    assign ifa.write_data = t_wd;
    assign ifa.sink_valid = t_v & ~sel;
    assign ifa.sink_data  = t_d;
    assign ifa.sink_sop   = t_sop;
    assign ifa.sink_eop   = t_eop;
    assign ifb.chipselect = t_cs & sel;
    assign ifb.read       = t_rd;
    assign ifb.write      = t_wr;
    assign ifb.address    = t_addr;
    assign ifb.write_data = t_wd;
    assign ifb.sink_valid = t_v & sel;
    assign ifb.sink_data  = t_d;
    assign ifb.sink_sop   = t_sop;
    assign ifb.sink_eop   = t_eop;
    assign obs_ready = sel ? ifb.sink_ready : ifa.sink_ready;
    assign obs_rd    = sel ? ifb.read_data  : ifa.read_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: mode uses the STATUS state numbering (0 idle, 1 wait sop, 2 capture, 3 done)
    int          m_flen, m_mode, m_bin, m_frames, m_errcnt;
    bit          m_err, m_done, m_cont, m_up;
    int unsigned m_q[$];

    function automatic void model_reset(input int flen, input bit up);
        m_flen = flen; m_mode = 0; m_bin = 0; m_frames = 0; m_errcnt = 0;
        m_err = 0; m_done = 0; m_cont = 0; m_up = up;
        m_q.delete();
    endfunction

    function automatic int unsigned m_status();
        int unsigned lvl = m_q.size();
        return lvl | (m_done ? 32'h100 : 0) | (m_err ? 32'h200 : 0) | (m_mode << 10)
             | ((lvl == DEPTH) ? 32'h1000 : 0) | ((lvl == 0) ? 32'h2000 : 0);
    endfunction

    function automatic int unsigned m_count();
`ifdef FFT_CAPTURE_ERR_CNT_EN
        return (m_errcnt << 16) | m_frames;
`else
        return m_frames;
`endif
    endfunction

    task automatic step(input bit v, input bit sop, input bit eop, input int unsigned d,
                        input bit rd, input int unsigned addr, input bit wr,
                        input int unsigned wd, output bit xf);
        bit ready, pop, push, ctl, clear, abort, resync, early, last;
        int unsigned exp_rd;
        int new_mode;
        string tag;
        t_v = v; t_sop = sop; t_eop = eop; t_d = 28'(d);
        t_cs = rd | wr; t_rd = rd; t_wr = wr; t_addr = 2'(addr); t_wd = wd;

        ready = m_up && (m_mode != 2 || m_q.size() < DEPTH);
        check("sink_ready", obs_ready, ready);
        xf = v && ready;
        pop = 0; push = 0; exp_rd = 0; tag = "rd";
        case (addr)
            0: begin tag = "rd_data";
                     if (m_q.size() > 0) begin exp_rd = m_q[0]; pop = rd; end end
            1: begin tag = "rd_status"; exp_rd = m_status(); end
            2: begin tag = "rd_ctrl";   exp_rd = m_cont ? 2 : 0; end
            default: begin tag = "rd_count"; exp_rd = m_count(); end
        endcase
        ctl   = wr && addr == 2;
        clear = ctl && wd[2];
        abort = ctl && wd[3];

        new_mode = m_mode;
        if (xf && (m_mode == 2 || (m_mode == 1 && sop))) push = (m_q.size() < DEPTH);
        if (m_mode == 1 && xf && sop) begin
            new_mode = 2; m_bin = 1;
        end else if (m_mode == 2 && xf) begin
            resync = sop && m_bin != 0;
            early  = eop && m_bin != m_flen - 1;
            if (resync || early) begin
                m_err = 1;
                if (m_errcnt < 65535) m_errcnt++;
            end
            last = eop || (!resync && m_bin == m_flen - 1);
            if (last) begin
                m_frames = (m_frames + 1) % 65536; m_done = 1; m_bin = 0;
                new_mode = m_cont ? 1 : 3;
            end else begin
                m_bin = resync ? 1 : m_bin + 1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push && !clear && !abort) m_q.push_back(d & 32'h0FFF_FFFF);
        if (ctl) begin
            if (wd[0] && (m_mode == 0 || m_mode == 3)) new_mode = 1;
            m_cont = wd[1];
            if (clear) begin
                m_err = 0; m_done = 0; m_frames = 0; m_errcnt = 0; m_q.delete();
            end
            if (abort) begin new_mode = 0; m_bin = 0; end
        end
        m_mode = new_mode;

        @(posedge clk);
        m_up = 1;
        @(negedge clk);
        last_rd = obs_rd;
        if (rd) check(tag, obs_rd, exp_rd);
        t_v = 0; t_sop = 0; t_eop = 0; t_cs = 0; t_rd = 0; t_wr = 0;
    endtask

    task automatic wr_ctrl(input int unsigned wd);
        bit xf;
        step(0, 0, 0, 0, 0, 2, 1, wd, xf);
    endtask

    task automatic rd_reg(input int unsigned addr);
        bit xf;
        step(0, 0, 0, 0, 1, addr, 0, 0, xf);
    endtask

    task automatic send(input bit sop, input bit eop, input int unsigned d, input bit rd_too);
        bit xf;
        int n = 0;
        do begin
            step(1, sop, eop, d, rd_too, 0, 0, 0, xf);
            n++;
        end while (!xf && n < 50);
        check("send_accept", xf, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit xf;
        int k;
        sel = 0; reset_n = 0;
        t_cs = 0; t_rd = 0; t_wr = 0; t_v = 0; t_sop = 0; t_eop = 0;
        t_addr = 0; t_wd = 0; t_d = 0;
        #1;
        check("reset_ready", ifa.sink_ready, 0);
        check("reset_rdata", ifa.read_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset(8, 0);
        rd_reg(1);
        check("reset_status", last_rd, 32'h2000);

        // Single 8-bin frame, then drain with one extra read on empty
        wr_ctrl(1);
        for (int i = 1; i <= 8; i++) send(i == 1, i == 8, i, 0);
        rd_reg(1);
        check("frame_status", last_rd, 32'h0D08);
        for (int i = 0; i < 9; i++) rd_reg(0);
        check("empty_read", last_rd, 0);

        // Mid-frame sop resynchronises; done only after 8 transfers from it
        wr_ctrl(4);
        wr_ctrl(1);
        send(1, 0, 10, 0); send(0, 0, 11, 0); send(0, 0, 12, 0); send(1, 0, 13, 0);
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) rd_reg(1);
            send(0, i == 7, 13 + i, 0);
        end
        rd_reg(1);
        check("resync_status", last_rd, 32'h0F0B);
        rd_reg(3);
`ifdef FFT_CAPTURE_ERR_CNT_EN
        check("resync_count", last_rd, 32'h0001_0001);
`else
        check("resync_count", last_rd, 32'h0000_0001);
`endif
        for (int i = 0; i < 11; i++) rd_reg(0);

        // Three back-to-back continuous frames with a read every cycle
        wr_ctrl(4);
        wr_ctrl(3);
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) send(i == 0, i == 7, 100 + f * 8 + i, 1);
        for (int i = 0; i < 4; i++) rd_reg(0);
        rd_reg(3);
        check("cont_count", last_rd, 3);
        rd_reg(1);
        check("cont_status", last_rd, 32'h2500);
        rd_reg(2);
        check("cont_ctrl", last_rd, 2);
        wr_ctrl(0);

        // Clear coincident with a push at level 5
        send(1, 0, 1, 0); send(0, 0, 2, 0); send(1, 0, 3, 0); send(0, 0, 4, 0); send(0, 0, 5, 0);
        step(1, 0, 0, 6, 0, 2, 1, 4, xf);
        rd_reg(1);
        check("clear_status", last_rd, 32'h2800);
        rd_reg(3);
        check("clear_count", last_rd, 0);
        wr_ctrl(8);

        // Asynchronous reset mid-capture
        wr_ctrl(1);
        for (int i = 0; i < 4; i++) send(i == 0, 0, 20 + i, 0);
        rd_reg(1);
        #3 reset_n = 0;
        #1;
        check("async_rst_rdata", ifa.read_data, 0);
        check("async_rst_ready", ifa.sink_ready, 0);
        @(negedge clk);
        reset_n = 1;
        model_reset(8, 0);
        rd_reg(1);
        check("post_rst_status", last_rd, 32'h2000);
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, 40 + i, 0);
        rd_reg(1);
        check("unarmed_status", last_rd, 32'h2000);
        wr_ctrl(1);
        rd_reg(1);
        check("rearm_status", last_rd, 32'h2400);

        // Random traffic on instance A
        wr_ctrl(8);
        wr_ctrl(4);
        for (int c = 0; c < 600; c++) begin
            bit v, sop, eop, rd, wr;
            int unsigned addr, wd;
            v   = ($urandom % 4) != 0;
            sop = (m_mode != 2) ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
            eop = ($urandom % 10) == 0;
            rd  = ($urandom % 5) < 2;
            wr  = !rd && (($urandom % 20) == 0);
            addr = ($urandom % 2) ? 0 : $urandom % 4;
            if (wr) addr = (($urandom % 4) == 0) ? $urandom % 4 : 2;
            wd = 1 | (($urandom % 2) << 1) | ((($urandom % 8) == 0) ? 4 : 0)
                   | ((($urandom % 10) == 0) ? 8 : 0);
            step(v, sop, eop, $urandom, rd, addr, wr, wd, xf);
        end

        // Backpressure on instance B: FIFO fills, one read lets exactly one more bin in
        sel = 1;
        model_reset(32, 1);
        wr_ctrl(1);
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) check("full_ready", obs_ready, 0);
            step(1, k == 0, 0, 200 + k, c == 25, 0, 0, 0, xf);
            if (xf) k++;
        end
        check("bp_accepted", k, 17);
        for (int i = 0; i < 16; i++) rd_reg(0);
        check("bp_last_value", last_rd, 216);
        wr_ctrl(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
